ads_multich_capture: RTL

- Parametrised successor to the single-channel ADS1672-EVM controller.
- Captures NUM_CH synchronous ADS167x-style serial ADCs in parallel. All channels share the serial clock, START and DRDY_n; each channel has its own data line.
- Supports single-shot and continuous acquisition, a DRDY timeout and a one-frame output buffer with overrun counting.
- Presents samples as a valid/ready stream, one channel word per beat, to the downstream packetiser.

---
 rtl/ads_multich_capture_if.sv | 16 +
 rtl/ads_multich_capture.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ads_multich_capture_if.sv
// Sample stream from the multichannel ADC capture block to the downstream packetiser.
interface ads_multich_capture_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2
) ();
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_WIDTH-1:0] m_data;
  logic [CW-1:0]         m_chan;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, m_chan, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_chan, m_last, m_valid, output m_ready);
endinterface

// File: rtl/ads_multich_capture.sv
// Parallel capture of NUM_CH ADS167x-style serial ADCs sharing START/DRDY_n/SCLK,
// presenting each frame as NUM_CH stream beats through a one-frame buffer.
module ads_multich_capture #(
  parameter int DATA_WIDTH     = 24,
  parameter int NUM_CH         = 2,
  parameter int START_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          measure,
  input  logic                          run,
  output logic                          sclk,
  input  logic                          drdy_n,
  input  logic [NUM_CH-1:0]             drr,
  output logic                          start,
  output logic                          busy,
  ads_multich_capture_if.master         m,
  output logic                          timeout_err,
  output logic [15:0]                   overrun_cnt
);

  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TOW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  CH_LAST    = CW'(NUM_CH - 1);
  localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LIMIT   = TOW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HIGH,
    S_WAIT_DRDY,
    S_SHIFT
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_cont;
  logic                  w_next_cont;
  logic [SCW-1:0]        r_start_ct;
  logic [BCW-1:0]        r_bit_ct;
  logic [TOW-1:0]        r_to_ct;
  logic                  w_in_wait;
  logic                  w_to_expired;
  logic                  w_to_hit;
  logic                  r_timeout_err;

  // Bit 0 is never stored: the final bit is taken straight from drr at hand-off.
  logic [DATA_WIDTH-1:1] r_shift [NUM_CH];
  logic [DATA_WIDTH-1:0] w_frame [NUM_CH];
  logic [DATA_WIDTH-1:0] r_buf   [NUM_CH];
  logic                  r_valid;
  logic [CW-1:0]         r_beat;
  logic [15:0]           r_overrun;

  logic                  w_frame_done;
  logic                  w_beat_xfer;
  logic                  w_last_xfer;
  logic                  w_load;

  assign sclk = clk;

  assign w_in_wait    = (r_state == S_WAIT_HIGH) || (r_state == S_WAIT_DRDY);
  assign w_to_expired = (TIMEOUT_CYCLES != 0) && w_in_wait && (r_to_ct == TO_LIMIT);
  assign w_frame_done = (r_state == S_SHIFT) && (r_bit_ct == BIT_LAST);
  assign w_beat_xfer  = r_valid && m.m_ready;
  assign w_last_xfer  = w_beat_xfer && (r_beat == CH_LAST);
  assign w_load       = w_frame_done && (!r_valid || w_last_xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cont  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cont  <= w_next_cont;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cont  = r_cont;
    w_to_hit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_START;
          w_next_cont  = 1'b1;
        end else if (measure) begin
          w_next_state = S_START;
          w_next_cont  = 1'b0;
        end
      end
      S_START: begin
        if (r_start_ct == START_LAST) w_next_state = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (r_cont && !run) begin
          w_next_state = S_IDLE;
        end else if (w_to_expired) begin
          w_next_state = S_IDLE;
          w_to_hit     = 1'b1;
        end else if (drdy_n) begin
          w_next_state = S_WAIT_DRDY;
        end
      end
      S_WAIT_DRDY: begin
        if (r_cont && !run) begin
          w_next_state = S_IDLE;
        end else if (w_to_expired) begin
          w_next_state = S_IDLE;
          w_to_hit     = 1'b1;
        end else if (!drdy_n) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_ct == BIT_LAST) w_next_state = (r_cont && run) ? S_WAIT_HIGH : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_ct    <= '0;
      r_bit_ct      <= '0;
      r_to_ct       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start_ct    <= (r_state == S_START) ? r_start_ct + 1'b1 : '0;
      r_bit_ct      <= (r_state == S_SHIFT) ? r_bit_ct + 1'b1 : '0;
      // Restarts on every wait-state entry, so each wait gets its own budget.
      r_to_ct       <= (w_in_wait && (w_next_state == r_state)) ? r_to_ct + 1'b1 : '0;
      r_timeout_err <= w_to_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) r_shift[ch] <= '0;
    end else if ((r_state == S_SHIFT) && (r_bit_ct != BIT_LAST)) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) r_shift[ch][BIT_LAST - r_bit_ct] <= drr[ch];
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) w_frame[ch] = {r_shift[ch], drr[ch]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) r_buf[ch] <= '0;
      r_valid   <= 1'b0;
      r_beat    <= '0;
      r_overrun <= '0;
    end else begin
      if (w_load) begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) r_buf[ch] <= w_frame[ch];
        r_valid <= 1'b1;
        r_beat  <= '0;
      end else if (w_beat_xfer) begin
        if (r_beat == CH_LAST) begin
          r_valid <= 1'b0;
          r_beat  <= '0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (w_frame_done && !w_load && (r_overrun != '1)) r_overrun <= r_overrun + 1'b1;
    end
  end

  assign start       = (r_state == S_START);
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;
  assign overrun_cnt = r_overrun;

  assign m.m_data  = r_buf[r_beat];
  assign m.m_chan  = r_beat;
  assign m.m_last  = r_valid && (r_beat == CH_LAST);
  assign m.m_valid = r_valid;

endmodule
